// File: rtl/display_scheduler.sv
// Round-robin time-sharing of the 8-digit display between three requesters.
// Optional expiry blink of the digit mask is enabled by defining DISP_BLINK_EN.
module display_scheduler #(
  parameter int          CLK_DIV   = 100000,
  parameter int          HOLD_MS   = 2000,
  parameter int          GAP_MS    = 100,
  parameter logic [31:0] IDLE_DATA = 32'h0000_0000
) (
  input  logic        CP,
  input  logic        RST,
  input  logic [2:0]  REQ,
  input  logic [31:0] DATA0,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic [2:0]  GRANT,
  output logic [2:0]  DONE,
  output logic [31:0] DISP_DATA,
  output logic [7:0]  DISP_MASK,
  output logic        BUSY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MS_MAX = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
  localparam int MSW    = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [MSW-1:0] HOLD_LAST  = MSW'(HOLD_MS - 1);
  localparam logic [MSW-1:0] GAP_LAST   = (GAP_MS > 0) ? MSW'(GAP_MS - 1) : '0;
  localparam logic [1:0]     LEAVE_ST   = (GAP_MS == 0) ? S_IDLE : S_GAP;

  logic [1:0]     state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [MSW-1:0] ms_q, ms_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     sel_q, sel_d;
  logic [2:0]     grant_q, grant_d;
  logic [2:0]     done_q, done_d;
  logic [31:0]    disp_data_q, disp_data_d;

  logic           tick;
  logic [1:0]     cand1, cand2, pick;
  logic [31:0]    data_sel;
  logic [7:0]     show_mask;

  function automatic logic [1:0] next_idx(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  // Search order starts just after the last owner, so a continuous requester waits its turn.
  always_comb begin
    cand1 = next_idx(ptr_q);
    cand2 = next_idx(cand1);
    if (REQ[cand1])      pick = cand1;
    else if (REQ[cand2]) pick = cand2;
    else                 pick = ptr_q;
  end

  always_comb begin
    case (sel_q)
      2'd0:    data_sel = DATA0;
      2'd1:    data_sel = DATA1;
      default: data_sel = DATA2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    done_d  = 3'b000;
    presc_d = tick ? '0 : presc_q + PW'(1);
    case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          state_d = S_SHOW;
          sel_d   = pick;
          ptr_d   = pick;
          grant_d = 3'b001 << pick;
          ms_d    = '0;
        end
      end
      S_SHOW: begin
        // Release wins over a final tick landing in the same cycle.
        if (!REQ[sel_q]) begin
          state_d = LEAVE_ST;
          grant_d = 3'b000;
          ms_d    = '0;
        end else if (tick && (ms_q == HOLD_LAST)) begin
          state_d = LEAVE_ST;
          grant_d = 3'b000;
          done_d  = grant_q;
          ms_d    = '0;
        end else if (tick) begin
          ms_d = ms_q + MSW'(1);
        end
      end
      S_GAP: begin
        if (tick) begin
          if (ms_q == GAP_LAST) begin
            state_d = S_IDLE;
            ms_d    = '0;
          end else begin
            ms_d = ms_q + MSW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 3'b000;
        ms_d    = '0;
      end
    endcase
    if (state_d != state_q) presc_d = '0;
    // First SHOW cycle still shows idle data; the owner's word lands one cycle after grant.
    disp_data_d = ((state_q == S_SHOW) && (state_d == S_SHOW)) ? data_sel : IDLE_DATA;
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      ms_q        <= '0;
      ptr_q       <= 2'd2;
      sel_q       <= 2'd0;
      grant_q     <= 3'b000;
      done_q      <= 3'b000;
      disp_data_q <= IDLE_DATA;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      disp_data_q <= disp_data_d;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BLINK_PER   = (HOLD_MS / 16 > 0) ? HOLD_MS / 16 : 1;
  localparam int BW          = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
  localparam int BLINK_START = HOLD_MS - HOLD_MS / 4;

  logic          blink_on_q, blink_on_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          in_window;

  assign in_window = (state_q == S_SHOW) && (ms_q >= MSW'(BLINK_START));

  always_comb begin
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q;
    if (!in_window) begin
      blink_on_d  = 1'b0;
      blink_cnt_d = '0;
    end else if (tick) begin
      if (blink_cnt_q == BW'(BLINK_PER - 1)) begin
        blink_on_d  = ~blink_on_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      blink_on_q  <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign show_mask = (in_window && !blink_on_q) ? 8'h00 : 8'hFF;
`else
  assign show_mask = 8'hFF;
`endif

  always_comb begin
    case (state_q)
      S_SHOW:  DISP_MASK = show_mask;
      S_GAP:   DISP_MASK = 8'h00;
      default: DISP_MASK = 8'hFF;
    endcase
  end

  assign GRANT     = grant_q;
  assign DONE      = done_q;
  assign DISP_DATA = disp_data_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule
